pm_load_controller: RTL and testbench
=====================================

Name: pm_load_controller

Overview:
- Owns the program memory port and shares it between the CPU instruction fetch path and a byte-serial program loader.
- In RUN, the block passes CPU fetch addresses straight to program memory and returns the instruction word.
- In PROG, it stalls the CPU and assembles little-endian byte pairs into instruction words. It writes them to consecutive addresses from 0, then issues a CPU restart pulse.
- Sits between the CPU core, the program memory and the host/UART loader.

Parameters:
ADDRESS_WIDTH, 8, program memory address width (depth = 2**ADDRESS_WIDTH)
DATA_WIDTH, 12, instruction word width; legal range 9..16

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  synchronous active-low reset
prog_req  in  1  level; 1 = host requests programming mode
ld_valid  in  1  loader byte valid
ld_data  in  8  loader byte
ld_last  in  1  qualifies the high byte of the final word
ld_ready  out  1  block accepts ld_data this cycle
cpu_addr  in  ADDRESS_WIDTH  CPU fetch address
cpu_instr  out  DATA_WIDTH  instruction to CPU
cpu_stall  out  1  CPU must hold PC/state
cpu_restart  out  1  one-cycle pulse; CPU resets PC to 0
pm_addr  out  ADDRESS_WIDTH  program memory address
pm_rdata  in  DATA_WIDTH  program memory combinational read data
pm_we  out  1  program memory write enable, sampled at clk edge
pm_wdata  out  DATA_WIDTH  program memory write data
prog_done  out  1  one-cycle pulse at end of programming
prog_err  out  1  sticky error: abort or overflow
words_written  out  ADDRESS_WIDTH+1  words committed in last/current session

Behaviour:
- Reset (rst_n=0 at edge): state RUN, wr_ptr=0, lo_byte=0, hi_byte=0, words_written=0, prog_err=0.
- Outputs after reset: ld_ready=0, cpu_stall=0, cpu_restart=0, pm_we=0, prog_done=0.
- Reset mid-programming abandons the session; no further write occurs.

States: RUN, LOAD_LO, LOAD_HI, WRITE, DONE.

RUN:
- pm_addr=cpu_addr; cpu_instr=pm_rdata combinationally, zero added latency.
- cpu_stall=0; ld_ready=0.
- prog_req=1 → LOAD_LO. On that edge: wr_ptr=0, words_written=0, prog_err=0.

LOAD_LO:
- ld_ready=1; cpu_stall=1.
- ld_valid=1 → capture lo_byte, go LOAD_HI. ld_last is ignored in this state.

LOAD_HI:
- ld_ready=1; cpu_stall=1.
- ld_valid=1 → capture hi_byte, latch last_flag=ld_last, go WRITE.

WRITE (exactly 1 cycle):
- ld_ready=0; pm_we=1; pm_addr=wr_ptr.
- pm_wdata={hi_byte,lo_byte}[DATA_WIDTH-1:0]; upper unused bits discarded.
- At edge: wr_ptr+1, words_written+1.
- Next state:
  - last_flag=1 → DONE.
  - else wr_ptr==2**ADDRESS_WIDTH-1 → prog_err=1, DONE (overflow; memory full).
  - else → LOAD_LO.

DONE:
- cpu_stall=1; ld_ready=0.
- prog_done=1 and cpu_restart=1 for the first cycle in DONE only.
- Stays in DONE while prog_req=1; prog_req=0 → RUN.

Other rules:
- Abort: prog_req=0 while in LOAD_LO/LOAD_HI → prog_err=1, partial word discarded (no pm_we), go DONE.
- prog_req changes during WRITE are ignored until the next state.
- cpu_instr in non-RUN states holds the value of the last RUN cycle (registered copy); the CPU sees no glitching instruction.
- pm_addr in LOAD_* and DONE = wr_ptr; pm_we=0 outside WRITE.
- Handshake: a byte transfers only when ld_valid & ld_ready at the clock edge. ld_valid without ld_ready is held by the loader, never dropped.
- ld_ready is a function of state only; there is no combinational path from ld_valid to ld_ready.
- prog_err remains set through RUN until the next programming session starts.

Test Plan:
- Reset: hold rst_n=0 3 cycles with prog_req=1, ld_valid=1 → no pm_we; all outputs at reset values; state RUN one cycle after release, then LOAD_LO.
- RUN passthrough: preload mem[5]=12'hA3C, cpu_addr=5 → cpu_instr=12'hA3C same cycle; cpu_stall=0.
- Three-word load: prog_req=1; bytes 34,12 / 78,56 / BC,0A with ld_last on 0A → writes mem[0]=12'h234, mem[1]=12'h678, mem[2]=12'hABC. Then prog_done=1 and cpu_restart=1 for one cycle, words_written=3, prog_err=0. prog_req=0 → RUN; cpu_addr=1 reads 12'h678.
- Backpressure/gaps: insert 2 idle cycles (ld_valid=0) between every byte → same memory contents. Exactly one pm_we pulse per word; ld_ready=0 in every WRITE cycle.
- Abort: drop prog_req after the low byte of word 1 → mem[0] written, mem[1] unchanged, prog_err=1, words_written=1, prog_done pulses once.
- Overflow: ADDRESS_WIDTH=2, send 5 words with no ld_last → 4 writes (addresses 0..3), prog_err=1, words_written=4, 5th word's bytes never accepted (ld_ready=0).

Source files
------------

// File: rtl/pm_load_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pm_load_controller_if
//  Description : Bundle of loader handshake, CPU fetch, program memory and
//                status signals around the program-memory load controller.
//                'slave' is the controller's view; 'master' is the view of
//                everything around it (CPU, memory, host loader).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pm_load_controller_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 12
);
    // Host / loader side
    logic                     prog_req;
    logic                     ld_valid;
    logic [7:0]               ld_data;
    logic                     ld_last;
    logic                     ld_ready;
    // CPU side
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]    cpu_instr;
    logic                     cpu_stall;
    logic                     cpu_restart;
    // Program memory side
    logic [ADDRESS_WIDTH-1:0] pm_addr;
    logic [DATA_WIDTH-1:0]    pm_rdata;
    logic                     pm_we;
    logic [DATA_WIDTH-1:0]    pm_wdata;
    // Status
    logic                     prog_done;
    logic                     prog_err;
    logic [ADDRESS_WIDTH:0]   words_written;

    modport slave (
        input  prog_req, ld_valid, ld_data, ld_last, cpu_addr, pm_rdata,
        output ld_ready, cpu_instr, cpu_stall, cpu_restart, pm_addr,
               pm_we, pm_wdata, prog_done, prog_err, words_written
    );

    modport master (
        output prog_req, ld_valid, ld_data, ld_last, cpu_addr, pm_rdata,
        input  ld_ready, cpu_instr, cpu_stall, cpu_restart, pm_addr,
               pm_we, pm_wdata, prog_done, prog_err, words_written
    );
endinterface
`default_nettype wire

// File: rtl/pm_load_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pm_load_controller
//  Description : Owns the program memory port. In RUN the CPU fetch address
//                passes straight through; in programming mode the CPU is
//                stalled while little-endian byte pairs from the loader are
//                packed into instruction words and written from address 0.
//                DATA_WIDTH must lie in 9..16.
//  Revision    : 1.0 - initial release
// ============================================================================
module pm_load_controller #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 12
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    pm_load_controller_if.slave bus
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_LOAD_LO = 3'd1,
        ST_LOAD_HI = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] c_PTR_MAX = '1;

    state_t                   r_state;
    state_t                   w_next;
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [7:0]               r_lo;
    logic [7:0]               r_hi;
    logic                     r_last;
    logic [ADDRESS_WIDTH:0]   r_words;
    logic                     r_err;
    logic                     r_done_first;
    logic [DATA_WIDTH-1:0]    r_instr_hold;

    logic                     w_ld_ready;
    logic                     w_stall;
    logic                     w_we;
    logic [ADDRESS_WIDTH-1:0] w_pm_addr;

    // Next-state and per-state outputs; ld_ready depends on state only
    always_comb begin
        w_next     = r_state;
        w_ld_ready = 1'b0;
        w_stall    = 1'b1;
        w_we       = 1'b0;
        w_pm_addr  = r_wr_ptr;
        case (r_state)
            ST_RUN: begin
                w_stall   = 1'b0;
                w_pm_addr = bus.cpu_addr;
                if (bus.prog_req) begin
                    w_next = ST_LOAD_LO;
                end
            end
            ST_LOAD_LO: begin
                w_ld_ready = 1'b1;
                if (!bus.prog_req) begin
                    w_next = ST_DONE;
                end else if (bus.ld_valid) begin
                    w_next = ST_LOAD_HI;
                end
            end
            ST_LOAD_HI: begin
                w_ld_ready = 1'b1;
                if (!bus.prog_req) begin
                    w_next = ST_DONE;
                end else if (bus.ld_valid) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // prog_req is deliberately not looked at here
                w_we = 1'b1;
                if (r_last || (r_wr_ptr == c_PTR_MAX)) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_LOAD_LO;
                end
            end
            ST_DONE: begin
                if (!bus.prog_req) begin
                    w_next = ST_RUN;
                end
            end
            default: begin
                w_next = ST_RUN;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Session datapath: byte capture, write pointer, counters and error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_lo         <= '0;
            r_hi         <= '0;
            r_last       <= 1'b0;
            r_words      <= '0;
            r_err        <= 1'b0;
            r_done_first <= 1'b0;
            r_instr_hold <= '0;
        end else begin
            // Pulse marks only the first cycle spent in DONE
            r_done_first <= (w_next == ST_DONE) && (r_state != ST_DONE);
            case (r_state)
                ST_RUN: begin
                    r_instr_hold <= bus.pm_rdata;
                    if (bus.prog_req) begin
                        r_wr_ptr <= '0;
                        r_words  <= '0;
                        r_err    <= 1'b0;
                    end
                end
                ST_LOAD_LO: begin
                    if (!bus.prog_req) begin
                        r_err <= 1'b1;
                    end else if (bus.ld_valid) begin
                        r_lo <= bus.ld_data;
                    end
                end
                ST_LOAD_HI: begin
                    if (!bus.prog_req) begin
                        r_err <= 1'b1;
                    end else if (bus.ld_valid) begin
                        r_hi   <= bus.ld_data;
                        r_last <= bus.ld_last;
                    end
                end
                ST_WRITE: begin
                    r_wr_ptr <= r_wr_ptr + ADDRESS_WIDTH'(1);
                    r_words  <= r_words + (ADDRESS_WIDTH + 1)'(1);
                    // Last address consumed without a final marker: memory full
                    if (!r_last && (r_wr_ptr == c_PTR_MAX)) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Word assembly: high byte bits above DATA_WIDTH are dropped
    generate
        if (DATA_WIDTH < 16) begin : g_trim
            logic w_unused_hi;
            assign w_unused_hi  = &{1'b0, r_hi[7:DATA_WIDTH-8]};
            assign bus.pm_wdata = {r_hi[DATA_WIDTH-9:0], r_lo};
        end else begin : g_full
            assign bus.pm_wdata = {r_hi, r_lo};
        end
    endgenerate

    assign bus.ld_ready      = w_ld_ready;
    assign bus.cpu_stall     = w_stall;
    assign bus.pm_we         = w_we;
    assign bus.pm_addr       = w_pm_addr;
    assign bus.cpu_instr     = (r_state == ST_RUN) ? bus.pm_rdata : r_instr_hold;
    assign bus.cpu_restart   = r_done_first;
    assign bus.prog_done     = r_done_first;
    assign bus.prog_err      = r_err;
    assign bus.words_written = r_words;

endmodule
`default_nettype wire

// File: tb/tb_pm_load_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pm_load_controller
//  Description : Two controller instances (256-word and 4-word memories) with
//                behavioural memories; sessions are checked against an
//                expected memory image and session summary kept here.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pm_load_controller;

    localparam int AW_A = 8;
    localparam int AW_B = 2;
    localparam int DW   = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pm_load_controller_if #(.ADDRESS_WIDTH(AW_A), .DATA_WIDTH(DW)) if_a ();
    pm_load_controller_if #(.ADDRESS_WIDTH(AW_B), .DATA_WIDTH(DW)) if_b ();

    pm_load_controller #(.ADDRESS_WIDTH(AW_A), .DATA_WIDTH(DW)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );
    pm_load_controller #(.ADDRESS_WIDTH(AW_B), .DATA_WIDTH(DW)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    // Stimulus, indexed by instance (0 = large, 1 = small)
    logic            prog_req_s [2];
    logic            ld_valid_s [2];
    logic [7:0]      ld_data_s  [2];
    logic            ld_last_s  [2];
    logic [AW_A-1:0] cpu_addr_a;
    logic [AW_B-1:0] cpu_addr_b;

    assign if_a.prog_req = prog_req_s[0];
    assign if_a.ld_valid = ld_valid_s[0];
    assign if_a.ld_data  = ld_data_s[0];
    assign if_a.ld_last  = ld_last_s[0];
    assign if_a.cpu_addr = cpu_addr_a;
    assign if_b.prog_req = prog_req_s[1];
    assign if_b.ld_valid = ld_valid_s[1];
    assign if_b.ld_data  = ld_data_s[1];
    assign if_b.ld_last  = ld_last_s[1];
    assign if_b.cpu_addr = cpu_addr_b;

    // Observed outputs, indexed by instance
    logic          rdy_o   [2];
    logic          stall_o [2];
    logic          rstrt_o [2];
    logic          we_o    [2];
    logic          done_o  [2];
    logic          err_o   [2];
    logic [31:0]   ww_o    [2];
    logic [DW-1:0] instr_o [2];

    assign rdy_o[0]   = if_a.ld_ready;
    assign stall_o[0] = if_a.cpu_stall;
    assign rstrt_o[0] = if_a.cpu_restart;
    assign we_o[0]    = if_a.pm_we;
    assign done_o[0]  = if_a.prog_done;
    assign err_o[0]   = if_a.prog_err;
    assign ww_o[0]    = 32'(if_a.words_written);
    assign instr_o[0] = if_a.cpu_instr;
    assign rdy_o[1]   = if_b.ld_ready;
    assign stall_o[1] = if_b.cpu_stall;
    assign rstrt_o[1] = if_b.cpu_restart;
    assign we_o[1]    = if_b.pm_we;
    assign done_o[1]  = if_b.prog_done;
    assign err_o[1]   = if_b.prog_err;
    assign ww_o[1]    = 32'(if_b.words_written);
    assign instr_o[1] = if_b.cpu_instr;

    // Behavioural program memories (combinational read, clocked write)
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [4];
    logic [DW-1:0] ref_a [256];
    logic [DW-1:0] ref_b [4];

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return 12'hA3C;
        return DW'((i * 37 + 91) ^ (i << 4));
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (if_a.pm_we) mem_a[if_a.pm_addr] <= if_a.pm_wdata;
        end
    end
    initial begin
        for (int i = 0; i < 4; i++) mem_b[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (if_b.pm_we) mem_b[if_b.pm_addr] <= if_b.pm_wdata;
        end
    end
    assign if_a.pm_rdata = mem_a[if_a.pm_addr];
    assign if_b.pm_rdata = mem_b[if_b.pm_addr];

    // Event counters, sampled mid-cycle
    int we_cnt [2]    = '{0, 0};
    int done_cnt [2]  = '{0, 0};
    int rstrt_cnt [2] = '{0, 0};
    int rdywe_cnt [2] = '{0, 0};
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (we_o[k])              we_cnt[k]    <= we_cnt[k] + 1;
            if (done_o[k])            done_cnt[k]  <= done_cnt[k] + 1;
            if (rstrt_o[k])           rstrt_cnt[k] <= rstrt_cnt[k] + 1;
            if (we_o[k] && rdy_o[k])  rdywe_cnt[k] <= rdywe_cnt[k] + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] sess_words [$];

    task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input int idx, input int a);
        return (idx == 1) ? ref_b[a] : ref_a[a];
    endfunction

    function automatic int pick_gap(input int g);
        return (g >= 0) ? g : int'($urandom_range(0, 2));
    endfunction

    // Offer one byte; called at a negedge, returns at a negedge
    task automatic send_byte(input int idx, input logic [7:0] d, input logic last,
                             input int gap, input int budget, output logic ok);
        repeat (gap) @(negedge clk);
        ld_data_s[idx]  = d;
        ld_last_s[idx]  = last;
        ld_valid_s[idx] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (rdy_o[idx]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        ld_valid_s[idx] = 1'b0;
        ld_last_s[idx]  = 1'b0;
    endtask

    // One programming session over sess_words; abort_at >= 0 drops prog_req
    // after that word's low byte
    task automatic run_session(input int idx, input bit use_last, input int abort_at, input int gap);
        int            depth, n_exp, bad;
        int            we0, d0, r0, rw0;
        bit            err_exp, aborted, is_last;
        logic          ok;
        logic [15:0]   w;
        logic [DW-1:0] hold_exp;
        depth   = (idx == 1) ? 4 : 256;
        n_exp   = 0;
        err_exp = 1'b0;
        aborted = 1'b0;
        we0 = we_cnt[idx]; d0 = done_cnt[idx]; r0 = rstrt_cnt[idx]; rw0 = rdywe_cnt[idx];
        hold_exp = ref_rd(idx, (idx == 1) ? int'(cpu_addr_b) : int'(cpu_addr_a));
        prog_req_s[idx] = 1'b1;
        for (int k = 0; k < sess_words.size(); k++) begin
            w       = sess_words[k];
            is_last = use_last && (k == sess_words.size() - 1);
            if (k >= depth) begin
                send_byte(idx, w[7:0], 1'b0, 0, 6, ok);
                t_check("no_accept_when_full", 32'(ok), 32'd0);
                t_check("ready_low_when_full", 32'(rdy_o[idx]), 32'd0);
                break;
            end
            send_byte(idx, w[7:0], 1'($urandom_range(0, 1)), pick_gap(gap), 40, ok);
            t_check("lo_accept", 32'(ok), 32'd1);
            if (k == abort_at) begin
                prog_req_s[idx] = 1'b0;
                err_exp = 1'b1;
                aborted = 1'b1;
                break;
            end
            send_byte(idx, w[15:8], is_last, pick_gap(gap), 40, ok);
            t_check("hi_accept", 32'(ok), 32'd1);
            if (idx == 1) ref_b[k] = w[DW-1:0];
            else          ref_a[k] = w[DW-1:0];
            n_exp++;
            if (is_last) break;
            if (k == depth - 1) err_exp = 1'b1;
        end
        for (int n = 0; n < 40 && done_cnt[idx] == d0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        if (!aborted) begin
            t_check("stall_in_done", 32'(stall_o[idx]), 32'd1);
            t_check("instr_hold", 32'(instr_o[idx]), 32'(hold_exp));
        end
        prog_req_s[idx] = 1'b0;
        repeat (2) @(negedge clk);
        t_check("stall_back_in_run", 32'(stall_o[idx]), 32'd0);
        t_check("words_written", ww_o[idx], 32'(n_exp));
        t_check("prog_err", 32'(err_o[idx]), 32'(err_exp));
        t_check("we_pulses", 32'(we_cnt[idx] - we0), 32'(n_exp));
        t_check("done_pulses", 32'(done_cnt[idx] - d0), 32'd1);
        t_check("restart_pulses", 32'(rstrt_cnt[idx] - r0), 32'd1);
        t_check("ready_during_write", 32'(rdywe_cnt[idx] - rw0), 32'd0);
        bad = 0;
        for (int i = 0; i < depth; i++) begin
            if (idx == 1) begin
                if (mem_b[i] !== ref_b[i]) bad++;
            end else begin
                if (mem_a[i] !== ref_a[i]) bad++;
            end
        end
        t_check("mem_contents_bad_words", 32'(bad), 32'd0);
    endtask

    task automatic run_read(input int idx);
        int a;
        @(negedge clk);
        if (idx == 1) begin
            a = int'($urandom_range(0, 3));
            cpu_addr_b = AW_B'(a);
        end else begin
            a = int'($urandom_range(0, 255));
            cpu_addr_a = AW_A'(a);
        end
        #1;
        t_check("run_read", 32'(instr_o[idx]), 32'(ref_rd(idx, a)));
        t_check("run_no_stall", 32'(stall_o[idx]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ab;
        for (int i = 0; i < 256; i++) ref_a[i] = init_val(i);
        for (int i = 0; i < 4; i++)   ref_b[i] = init_val(i);
        for (int k = 0; k < 2; k++) begin
            prog_req_s[k] = 1'b1;
            ld_valid_s[k] = 1'b1;
            ld_data_s[k]  = 8'h55;
            ld_last_s[k]  = 1'b1;
        end
        cpu_addr_a = '0;
        cpu_addr_b = '0;

        // Reset held with requests pending
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            t_check("rst_we", 32'(we_o[0]), 32'd0);
            t_check("rst_ready", 32'(rdy_o[0]), 32'd0);
            t_check("rst_stall", 32'(stall_o[0]), 32'd0);
            t_check("rst_restart", 32'(rstrt_o[0]), 32'd0);
            t_check("rst_done", 32'(done_o[0]), 32'd0);
            t_check("rst_ww", ww_o[0], 32'd0);
            t_check("rst_err", 32'(err_o[0]), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        t_check("post_rst_run_ready", 32'(rdy_o[0]), 32'd0);
        t_check("post_rst_run_stall", 32'(stall_o[0]), 32'd0);
        @(negedge clk);
        t_check("post_rst_loadlo_ready", 32'(rdy_o[0]), 32'd1);
        t_check("post_rst_loadlo_stall", 32'(stall_o[0]), 32'd1);
        // Abandon that session through reset
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            prog_req_s[k] = 1'b0;
            ld_valid_s[k] = 1'b0;
            ld_last_s[k]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        t_check("no_write_through_reset", 32'(we_cnt[0] + we_cnt[1]), 32'd0);
        t_check("reset_ready_b", 32'(rdy_o[1]), 32'd0);

        // RUN passthrough
        cpu_addr_a = 8'd5;
        #1;
        t_check("run_passthrough", 32'(instr_o[0]), 32'h0A3C);
        t_check("run_passthrough_stall", 32'(stall_o[0]), 32'd0);

        // Three-word load, back to back
        sess_words = '{16'h1234, 16'h5678, 16'h0ABC};
        run_session(0, 1'b1, -1, 0);
        t_check("mem0", 32'(mem_a[0]), 32'h234);
        t_check("mem1", 32'(mem_a[1]), 32'h678);
        t_check("mem2", 32'(mem_a[2]), 32'hABC);
        @(negedge clk);
        cpu_addr_a = 8'd1;
        #1;
        t_check("run_read_after_load", 32'(instr_o[0]), 32'h678);

        // Same load with two idle cycles before every byte
        sess_words = '{16'h1A2B, 16'h3C4D, 16'h5E6F};
        run_session(0, 1'b1, -1, 2);

        // Abort after the low byte of word 1
        sess_words = '{16'hF00D, 16'hBEEF, 16'h0123};
        run_session(0, 1'b1, 1, 0);

        // Overflow on the 4-word instance: five words, no final marker
        sess_words = '{16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555};
        run_session(1, 1'b0, -1, 0);

        // Exactly full with a final marker: no overflow error
        sess_words = '{16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04};
        run_session(1, 1'b1, -1, -1);

        // Randomised sessions
        for (int s = 0; s < 12; s++) begin
            n = int'($urandom_range(1, 8));
            sess_words = {};
            for (int k = 0; k < n; k++) sess_words.push_back(16'($urandom));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            cpu_addr_a = AW_A'($urandom_range(0, 255));
            @(negedge clk);
            run_session(0, 1'b1, ab, -1);
            run_read(0);
            run_read(0);
        end
        for (int s = 0; s < 6; s++) begin
            n = int'($urandom_range(1, 6));
            sess_words = {};
            for (int k = 0; k < n; k++) sess_words.push_back(16'($urandom));
            run_session(1, 1'b1, -1, -1);
            run_read(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
